// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave byte datapath blocks.
package i2c_pkg;

  localparam int I2C_BYTE_BITS = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2
  } i2c_rx_state_e;

endpackage

// File: rtl/i2c_slave_read_byte_if.sv
// Handshake between the command FSM, the synchronized bus lines and the byte receiver.
interface i2c_slave_read_byte_if
  import i2c_pkg::*;
#(
  parameter int BITS = I2C_BYTE_BITS
);
  logic            enable;
  logic            scl;
  logic            sda;
  logic [BITS-1:0] data;
  logic            finish;
  logic            error;
  logic            busy;

  modport slave (
    input  enable, scl, sda,
    output data, finish, error, busy
  );

  modport master (
    output enable, scl, sda,
    input  data, finish, error, busy
  );
endinterface

// File: rtl/i2c_scl_edge_detect.sv
// SCL edge detector; scl_last resets high so a line held low out of reset reads as a fall, not a rise.
module i2c_scl_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic scl,
  output logic rise,
  output logic fall
);
  logic scl_last;

  always_ff @(posedge clock) begin
    if (reset) scl_last <= 1'b1;
    else       scl_last <= scl;
  end

  assign rise = !scl_last &  scl;
  assign fall =  scl_last & !scl;
endmodule

// File: rtl/i2c_slave_read_byte.sv
// I2C slave byte receiver: samples SDA on SCL rise, MSB first, flags SDA moving while SCL is high.
module i2c_slave_read_byte
  import i2c_pkg::*;
#(
  parameter int BITS = I2C_BYTE_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  i2c_slave_read_byte_if.slave  bus
);
  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

  i2c_rx_state_e   state;
  logic [CW-1:0]   cnt;
  logic [BITS-1:0] data_q;
  logic            bit_val;
  logic            finish_q;
  logic            error_q;
  logic            busy_q;
  logic            rise;
  logic            fall;

  i2c_scl_edge_detect u_edge (
    .clock (clock),
    .reset (reset),
    .scl   (bus.scl),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      data_q   <= '0;
      bit_val  <= 1'b0;
      finish_q <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable) begin
            state   <= WAIT_RISE;
            cnt     <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        // A high phase already in progress at enable never produces a rise, so it is skipped.
        WAIT_RISE: begin
          if (rise) begin
            data_q  <= (data_q << 1) | BITS'(bus.sda);
            bit_val <= bus.sda;
            state   <= HIGH;
          end
        end
        HIGH: begin
          if (bus.scl && (bus.sda != bit_val)) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else if (fall) begin
            if (cnt == CW'(BITS - 1)) begin
              finish_q <= 1'b1;
              busy_q   <= 1'b0;
              state    <= IDLE;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= WAIT_RISE;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data   = data_q;
  assign bus.finish = finish_q;
  assign bus.error  = error_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_i2c_slave_read_byte.sv
// Directed bench for the I2C byte receiver: clean bytes, glitch abort, enable corner cases, reset abort.
module tb_i2c_slave_read_byte;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   fin_cnt = 0;
  logic [7:0] exp_data = 8'h00;

  i2c_slave_read_byte_if #(.BITS(8)) bus ();

  i2c_slave_read_byte #(.BITS(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (bus.finish === 1'b1) fin_cnt++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_word();
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    exp_data = 8'h00;
    chk("busy_after_enable", {31'd0, bus.busy}, 32'd1);
    chk("data_cleared", {24'd0, bus.data}, 32'd0);
    chk("error_cleared", {31'd0, bus.error}, 32'd0);
  endtask

  // One SCL pulse; for the last bit it returns in the finish cycle.
  task automatic send_bit(input logic b, input bit last, input bit mid_en);
    bus.sda = b;
    tick();
    bus.scl = 1'b1;
    tick();
    exp_data = {exp_data[6:0], b};
    chk("rise_data", {24'd0, bus.data}, {24'd0, exp_data});
    if (mid_en) begin
      bus.enable = 1'b1;
      tick();
      bus.enable = 1'b0;
    end else begin
      tick();
    end
    tick();
    chk("busy_in_high", {31'd0, bus.busy}, 32'd1);
    bus.scl = 1'b0;
    tick();
    if (last) begin
      chk("finish_pulse", {31'd0, bus.finish}, 32'd1);
      chk("busy_at_finish", {31'd0, bus.busy}, 32'd0);
      chk("error_at_finish", {31'd0, bus.error}, 32'd0);
      chk("data_at_finish", {24'd0, bus.data}, {24'd0, exp_data});
    end else begin
      chk("no_early_finish", {31'd0, bus.finish}, 32'd0);
      tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int en_bit);
    for (int i = 7; i >= 0; i--)
      send_bit(v[i], i == 0, (7 - i) == en_bit);
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.scl = 1'b1;
    bus.sda = 1'b1;
    tick(); tick(); tick();
    chk("rst_data", {24'd0, bus.data}, 32'd0);
    chk("rst_finish", {31'd0, bus.finish}, 32'd0);
    chk("rst_error", {31'd0, bus.error}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b0;
    tick();
    bus.scl = 1'b0;
    tick(); tick();

    // Clean byte A5
    start_word();
    send_byte(8'hA5, -1);
    tick();
    chk("finish_one_cycle", {31'd0, bus.finish}, 32'd0);
    chk("data_hold_a5", {24'd0, bus.data}, 32'h0000_00A5);
    chk("fin_cnt_t1", fin_cnt, 32'd1);

    // Glitch during bit 3 high phase
    start_word();
    send_bit(1'b1, 0, 0);
    send_bit(1'b0, 0, 0);
    bus.sda = 1'b1;
    tick();
    bus.scl = 1'b1;
    tick(); tick();
    bus.sda = 1'b0;
    tick();
    chk("glitch_error", {31'd0, bus.error}, 32'd1);
    chk("glitch_busy", {31'd0, bus.busy}, 32'd0);
    chk("glitch_partial_data", {24'd0, bus.data}, 32'h0000_0005);
    bus.scl = 1'b0;
    tick(); tick();
    chk("error_sticky", {31'd0, bus.error}, 32'd1);
    chk("fin_cnt_t2a", fin_cnt, 32'd1);
    start_word();
    send_byte(8'h12, -1);
    tick();
    chk("fin_cnt_t2b", fin_cnt, 32'd2);

    // Enable while SCL high: partial phase not counted
    bus.sda = 1'b1;
    bus.scl = 1'b1;
    tick(); tick();
    start_word();
    tick();
    chk("mid_high_no_sample", {24'd0, bus.data}, 32'd0);
    bus.scl = 1'b0;
    tick(); tick();
    send_byte(8'h3C, -1);
    tick();
    chk("data_3c", {24'd0, bus.data}, 32'h0000_003C);
    chk("fin_cnt_t3", fin_cnt, 32'd3);

    // Back-to-back: enable in the finish cycle
    start_word();
    send_byte(8'hFF, -1);
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    exp_data = 8'h00;
    chk("b2b_finish_low", {31'd0, bus.finish}, 32'd0);
    chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
    chk("b2b_data_cleared", {24'd0, bus.data}, 32'd0);
    send_byte(8'h00, -1);
    tick();
    chk("fin_cnt_t4", fin_cnt, 32'd5);

    // Reset mid-byte after 4 bits
    start_word();
    send_bit(1'b1, 0, 0);
    send_bit(1'b1, 0, 0);
    send_bit(1'b0, 0, 0);
    send_bit(1'b1, 0, 0);
    chk("pre_reset_data", {24'd0, bus.data}, 32'h0000_000D);
    reset = 1'b1;
    tick();
    chk("mid_rst_data", {24'd0, bus.data}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_error", {31'd0, bus.error}, 32'd0);
    chk("mid_rst_finish", {31'd0, bus.finish}, 32'd0);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("post_rst_idle", {31'd0, bus.busy}, 32'd0);
    start_word();
    send_byte(8'h81, -1);
    tick();
    chk("fin_cnt_t5", fin_cnt, 32'd6);

    // Ignored enable during bit 5
    start_word();
    send_byte(8'h5A, 4);
    tick();
    chk("data_5a", {24'd0, bus.data}, 32'h0000_005A);
    chk("fin_cnt_t6", fin_cnt, 32'd7);
    tick(); tick();
    chk("idle_busy_end", {31'd0, bus.busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
